// File: rtl/hex_display_ctrl_if.sv
// Host-side bus of the debug-display controller: update request, sampled values,
// status flags and the six active-low 7-segment patterns.
interface hex_display_ctrl_if;
    logic [31:0] PC;
    logic [4:0]  INC;
    logic        start;
    logic        busy;
    logic        done;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [6:0]  HEX3;
    logic [6:0]  HEX4;
    logic [6:0]  HEX5;

    modport master (
        output PC, INC, start,
        input  busy, done, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  PC, INC, start,
        output busy, done, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// Debug display: PC[7:0] as three decimal digits and INC as two, converted by one
// shared bit-serial divide-by-10 unit; the HEX outputs change together on commit.
module hex_display_ctrl #(
    parameter int REFRESH_CYCLES = 0,
    parameter int CNT_W          = 24
) (
    input  logic              clk,
    input  logic              reset,
    hex_display_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CAPTURE = 3'd1;
    localparam logic [2:0] DIV     = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] COMMIT  = 3'd4;

    localparam logic       JOB_PC   = 1'b0;
    localparam logic       JOB_INC  = 1'b1;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;
    localparam logic [CNT_W-1:0] REFRESH_LAST =
        CNT_W'(REFRESH_CYCLES == 0 ? 0 : REFRESH_CYCLES - 1);

    logic [2:0]       r_state;
    logic             r_pending;
    logic [CNT_W-1:0] r_refresh_cnt;
    logic [4:0]       r_inc_snap;
    logic [7:0]       r_quo;
    logic [3:0]       r_rem;
    logic [2:0]       r_bit_cnt;
    logic             r_job;
    logic             r_idx;
    logic [3:0]       r_sh0, r_sh1, r_sh2, r_sh4, r_sh5;
    logic [6:0]       r_hex0, r_hex1, r_hex2, r_hex4, r_hex5;

    logic             w_refresh_hit;
    logic             w_req;
    logic [11:0]      w_div_next;
    logic             w_unused_pc;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = 7'b1111111;
        endcase
    endfunction

    // One restoring step: r_quo shifts the dividend out of its MSB while the
    // quotient bits shift in at the LSB, so after 8 steps it holds the quotient.
    function automatic logic [11:0] div_step(input logic [3:0] rem, input logic [7:0] quo);
        logic [4:0] t;
        logic [4:0] d;
        t = {rem, quo[7]};
        d = t - 5'd10;
        if (t >= 5'd10) div_step = {d[3:0], quo[6:0], 1'b1};
        else            div_step = {t[3:0], quo[6:0], 1'b0};
    endfunction

    assign w_refresh_hit = (REFRESH_CYCLES != 0) && (r_refresh_cnt == REFRESH_LAST);
    assign w_req         = bus.start | w_refresh_hit;
    assign w_div_next    = div_step(r_rem, r_quo);
    assign w_unused_pc   = ^bus.PC[31:8];

    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == COMMIT);
    assign bus.HEX0 = r_hex0;
    assign bus.HEX1 = r_hex1;
    assign bus.HEX2 = r_hex2;
    assign bus.HEX3 = SEG_ZERO;
    assign bus.HEX4 = r_hex4;
    assign bus.HEX5 = r_hex5;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    r_refresh_cnt <= '0;
        else if (REFRESH_CYCLES == 0) r_refresh_cnt <= '0;
        else if (w_refresh_hit)       r_refresh_cnt <= '0;
        else                          r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pending  <= 1'b0;
            r_inc_snap <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_bit_cnt  <= '0;
            r_job      <= JOB_PC;
            r_idx      <= 1'b0;
            r_sh0      <= '0;
            r_sh1      <= '0;
            r_sh2      <= '0;
            r_sh4      <= '0;
            r_sh5      <= '0;
            r_hex0     <= SEG_ZERO;
            r_hex1     <= SEG_ZERO;
            r_hex2     <= SEG_ZERO;
            r_hex4     <= SEG_ZERO;
            r_hex5     <= SEG_ZERO;
        end else begin
            // COMMIT consumes its own request directly, so only mid-update requests latch here.
            if (w_req && r_state != IDLE && r_state != COMMIT) r_pending <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_req) r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_quo      <= bus.PC[7:0];
                    r_inc_snap <= bus.INC;
                    r_rem      <= '0;
                    r_bit_cnt  <= '0;
                    r_job      <= JOB_PC;
                    r_idx      <= 1'b0;
                    r_state    <= DIV;
                end
                DIV: begin
                    {r_rem, r_quo} <= w_div_next;
                    r_bit_cnt      <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) r_state <= WRITE;
                end
                WRITE: begin
                    r_rem <= '0;
                    if (r_job == JOB_INC) begin
                        r_sh4   <= r_rem;
                        r_sh5   <= r_quo[3:0];
                        r_state <= COMMIT;
                    end else if (!r_idx) begin
                        // The quotient left in r_quo is already the next dividend.
                        r_sh0   <= r_rem;
                        r_idx   <= 1'b1;
                        r_state <= DIV;
                    end else begin
                        r_sh1   <= r_rem;
                        r_sh2   <= r_quo[3:0];
                        r_quo   <= {3'b000, r_inc_snap};
                        r_job   <= JOB_INC;
                        r_state <= DIV;
                    end
                end
                COMMIT: begin
                    r_hex0 <= seg_encode(r_sh0);
                    r_hex1 <= seg_encode(r_sh1);
                    r_hex2 <= seg_encode(r_sh2);
                    r_hex4 <= seg_encode(r_sh4);
                    r_hex5 <= seg_encode(r_sh5);
                    if (r_pending || w_req) begin
                        r_pending <= 1'b0;
                        r_state   <= CAPTURE;
                    end else begin
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: table of conversions plus hand-written
// sequences for merged requests, reset abort and auto-refresh.
module tb_hex_display_ctrl;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  inc;
        logic [6:0]  h0, h1, h2, h4, h5;
    } vec_t;

    logic clk;
    logic rst;
    logic rst2;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    hex_display_ctrl_if if1();
    hex_display_ctrl_if if2();

    hex_display_ctrl dut (
        .clk   (clk),
        .reset (rst),
        .bus   (if1)
    );

    hex_display_ctrl #(.REFRESH_CYCLES(100), .CNT_W(8)) dut_ref (
        .clk   (clk),
        .reset (rst2),
        .bus   (if2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_hex(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e4, input logic [6:0] e5);
        chk({tag, ".HEX0"}, 64'(if1.HEX0), 64'(e0));
        chk({tag, ".HEX1"}, 64'(if1.HEX1), 64'(e1));
        chk({tag, ".HEX2"}, 64'(if1.HEX2), 64'(e2));
        chk({tag, ".HEX3"}, 64'(if1.HEX3), 64'(S0));
        chk({tag, ".HEX4"}, 64'(if1.HEX4), 64'(e4));
        chk({tag, ".HEX5"}, 64'(if1.HEX5), 64'(e5));
    endtask

    // Pulses start for one cycle, optionally scrambles inputs during DIV, and
    // returns edges from the request edge to the done cycle (-1 on timeout).
    task automatic run_update(input logic [31:0] pc, input logic [4:0] inc, input bit scramble,
                              output int lat, output logic busy_mid);
        int n;
        @(negedge clk);
        if1.PC = pc; if1.INC = inc; if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        n = cyc; lat = -1; busy_mid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 3) begin
                busy_mid = if1.busy;
                if (scramble) begin if1.PC = ~pc; if1.INC = ~inc; end
            end
            if (if1.done) begin lat = cyc - n; break; end
        end
    endtask

    vec_t vecs [7];

    initial begin
        int lat, n, d1, d2, changes, dones, prev, d;
        logic bm;
        logic [41:0] snap;
        logic [4:0]  incs [4];
        logic [6:0]  e4 [4];
        logic [6:0]  e5 [4];

        vecs[0] = '{32'h0000_007B, 5'd7,  S3, S2, S1, S7, S0};
        vecs[1] = '{32'hFFFF_FEFF, 5'd31, S5, S5, S2, S1, S3};
        vecs[2] = '{32'h0000_0000, 5'd0,  S0, S0, S0, S0, S0};
        vecs[3] = '{32'h0000_000A, 5'd10, S0, S1, S0, S0, S1};
        vecs[4] = '{32'h0000_0064, 5'd19, S0, S0, S1, S9, S1};
        vecs[5] = '{32'h0000_00C7, 5'd20, S9, S9, S1, S0, S2};
        vecs[6] = '{32'h1234_5609, 5'd9,  S9, S0, S0, S9, S0};
        incs = '{5'd3, 5'd17, 5'd25, 5'd30};
        e4   = '{S3, S7, S5, S0};
        e5   = '{S0, S1, S2, S3};

        rst = 1'b1; rst2 = 1'b1;
        if1.PC = '0; if1.INC = '0; if1.start = 1'b0;
        if2.PC = '0; if2.INC = '0; if2.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.hex", 64'({if1.HEX5, if1.HEX4, if1.HEX3, if1.HEX2, if1.HEX1, if1.HEX0}), 64'({6{S0}}));
        chk("reset.busy", 64'(if1.busy), 64'd0);
        chk("reset.done", 64'(if1.done), 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            run_update(vecs[k].pc, vecs[k].inc, 1'b1, lat, bm);
            chk($sformatf("vec%0d.latency", k), 64'(lat), 64'd28);
            chk($sformatf("vec%0d.busy_mid", k), 64'(bm), 64'd1);
            @(negedge clk);
            check_hex($sformatf("vec%0d", k), vecs[k].h0, vecs[k].h1, vecs[k].h2, vecs[k].h4, vecs[k].h5);
            chk($sformatf("vec%0d.idle_busy", k), 64'(if1.busy), 64'd0);
        end

        // Two extra requests during one update merge into a single back-to-back update.
        @(negedge clk);
        if1.PC = 32'd42; if1.INC = 5'd5; if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0; n = cyc;
        repeat (4) @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        repeat (6) @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        repeat (2) @(negedge clk);
        if1.PC = 32'd200; if1.INC = 5'd13;
        d1 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if1.done) begin d1 = cyc; break; end
        end
        chk("b2b.first_latency", 64'(d1 - n), 64'd28);
        @(negedge clk);
        check_hex("b2b.first", S2, S4, S0, S5, S0);
        chk("b2b.busy_no_idle", 64'(if1.busy), 64'd1);
        snap = {if1.HEX5, if1.HEX4, if1.HEX3, if1.HEX2, if1.HEX1, if1.HEX0};
        changes = 0; d2 = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ({if1.HEX5, if1.HEX4, if1.HEX3, if1.HEX2, if1.HEX1, if1.HEX0} !== snap) changes++;
            if (if1.done) begin d2 = cyc; break; end
        end
        chk("b2b.hex_stable", 64'(changes), 64'd0);
        chk("b2b.done_spacing", 64'(d2 - d1), 64'd29);
        @(negedge clk);
        check_hex("b2b.second", S0, S0, S2, S3, S1);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if1.done) dones++;
        end
        chk("b2b.no_third_done", 64'(dones), 64'd0);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        if1.PC = 32'd99; if1.INC = 5'd4; if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort.hex", 64'({if1.HEX5, if1.HEX4, if1.HEX3, if1.HEX2, if1.HEX1, if1.HEX0}), 64'({6{S0}}));
        chk("abort.busy", 64'(if1.busy), 64'd0);
        chk("abort.done", 64'(if1.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if1.done) dones++;
        end
        chk("abort.no_done", 64'(dones), 64'd0);
        chk("abort.hex_hold", 64'({if1.HEX5, if1.HEX4, if1.HEX2, if1.HEX1, if1.HEX0}), 64'({5{S0}}));
        run_update(32'd99, 5'd4, 1'b0, lat, bm);
        chk("abort.fresh_latency", 64'(lat), 64'd28);
        @(negedge clk);
        check_hex("abort.fresh", S9, S9, S0, S4, S0);

        // Auto-refresh every 100 cycles on the second instance.
        if2.PC = 32'h0000_0055; if2.INC = incs[0];
        @(negedge clk);
        rst2 = 1'b0;
        prev = cyc;
        for (int k = 0; k < 4; k++) begin
            d = -1;
            for (int i = 0; i < 150; i++) begin
                @(negedge clk);
                if (if2.done) begin d = cyc; break; end
            end
            chk($sformatf("refresh%0d.interval", k), 64'(d - prev), (k == 0) ? 64'd128 : 64'd100);
            prev = d;
            @(negedge clk);
            chk($sformatf("refresh%0d.HEX4", k), 64'(if2.HEX4), 64'(e4[k]));
            chk($sformatf("refresh%0d.HEX5", k), 64'(if2.HEX5), 64'(e5[k]));
            if (k == 0)
                chk("refresh.pc_digits", 64'({if2.HEX2, if2.HEX1, if2.HEX0}), 64'({S0, S8, S5}));
            if (k < 3) if2.INC = incs[k+1];
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Sequenced 7-segment display controller for the RV32IMF FPGA debug display.
- Shows PC[7:0] as 3 decimal digits on HEX2..HEX0 (HEX3 fixed '0') and the 5-bit instruction counter as 2 decimal digits on HEX5..HEX4.
- Uses one shared iterative divide-by-10 unit, time-multiplexed between the PC job and the INC job, instead of parallel dividers.
- HEX outputs change atomically when a full update completes.

Parameters:
- REFRESH_CYCLES, default 0: auto-refresh period in clk cycles. 0 disables auto-refresh.
- CNT_W, default 24: width of the refresh counter. Must satisfy 2^CNT_W > REFRESH_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- PC  in  32  program counter; only PC[7:0] is used.
- INC  in  5  instruction counter value.
- start  in  1  single-cycle update request.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when the HEX outputs update.
- HEX0..HEX5  out  7 each  active-low segment patterns (bit order g..a).

Behaviour:
- Segment encoding:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any code above 9 produces blank, 1111111. Blank is unreachable in normal operation.
- Reset (async):
  - HEX0..HEX5 = 1000000 ('0').
  - busy=0, done=0.
  - FSM to IDLE; pending flag, refresh counter and all shadow registers cleared.
- Request sources:
  - A request is start=1, or the refresh counter reaching REFRESH_CYCLES-1 when REFRESH_CYCLES != 0.
  - The refresh counter then wraps to 0. It free-runs regardless of busy.
- FSM states: IDLE, CAPTURE, DIV, WRITE, COMMIT.
  - IDLE: on a request, go to CAPTURE.
  - CAPTURE (1 cycle):
    - snapshot PC[7:0] to pc_snap and INC to inc_snap; busy=1.
    - dividend=pc_snap, job=PC, digit index=0.
    - Later input changes do not affect this update.
  - DIV (exactly 8 cycles): 8-bit restoring division by 10, MSB first, one quotient bit per cycle. Produces quotient[7:0] and remainder[3:0].
  - WRITE (1 cycle):
    - PC job, index 0: shadow0 = remainder; dividend = quotient; index=1; back to DIV.
    - PC job, index 1: shadow1 = remainder; shadow2 = quotient[3:0]; dividend = inc_snap zero-extended; job=INC; back to DIV.
    - INC job: shadow4 = remainder; shadow5 = quotient[3:0]; go to COMMIT.
  - COMMIT (1 cycle):
    - HEX0/1/2/4/5 = encode(shadow) on the clock edge leaving COMMIT; HEX3 stays 1000000.
    - done=1 for this cycle; busy=0 from the next cycle.
    - Go to CAPTURE if pending (pending cleared), otherwise IDLE.
- Latency:
  - Request sampled in IDLE at edge N; CAPTURE occupies the cycle after edge N.
  - done is high during the cycle after edge N+28.
  - CAPTURE 1 + DIV 8 + WRITE 1 + DIV 8 + WRITE 1 + DIV 8 + WRITE 1 + COMMIT 1 = 29 cycles.
  - New HEX values are visible at edge N+29.
- busy = 1 in CAPTURE, DIV, WRITE and COMMIT.
- Requests while busy:
  - Set the one-deep pending flag; further requests merge into it.
  - A request arriving in the COMMIT cycle also sets pending, so it causes a back-to-back update with no IDLE cycle.
- Simultaneous start and auto-refresh count as one request.
- Reset mid-conversion aborts immediately. HEX outputs return to '0' with no partial commit.
- Width rules:
  - Max PC value 255 gives digits 2,5,5. Max INC value 31 gives digits 3,1.
  - Quotient upper bits are always 0 at the final digit.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> all HEX = 1000000 immediately; busy=0, done=0.
- PC=32'h0000_007B, INC=7, pulse start -> done exactly 29 cycles later; HEX2/1/0 = 1111001/0100100/0110000 (1,2,3); HEX5=1000000 (0), HEX4=1111000 (7); HEX3=1000000.
- PC=32'hFFFF_FEFF, INC=31 -> upper PC bits ignored, PC[7:0]=255; HEX2..0 = 2,5,5; HEX5..4 = 3,1. Change PC during DIV -> result unchanged.
- Pulse start at cycles 5 and 12 after the first start -> exactly one extra update; second done arrives 29 cycles after the first done; HEX outputs stable between the two done pulses except at each done edge.
- Reset asserted at cycle 15 of a conversion of PC=99 -> no done pulse; HEX all '0'; a fresh start then completes normally with 0,9,9.
- REFRESH_CYCLES=100, no start, INC stepping -> done every 100 cycles; HEX4/5 track the INC value sampled at each CAPTURE.
